// File: rtl/vtx1_pipeline_monitor_if.sv
// Bundle between the VTX1 core side and the pipeline monitor.
// The master drives the pipeline strobes and controls; the slave (monitor) returns counters and status.
interface vtx1_pipeline_monitor_if #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 4,
  parameter int RUN_WIDTH = 16
);
  logic                              enable;
  logic                              clear;
  logic                              snapshot;
  logic                              retire;
  logic                              stall;
  logic                              flush;
  logic [NUM_EVT-1:0]                evt;
  logic [RUN_WIDTH-1:0]              wdt_limit;

  logic [CNT_WIDTH-1:0]              cycle_count;
  logic [CNT_WIDTH-1:0]              instr_count;
  logic [CNT_WIDTH-1:0]              stall_count;
  logic [CNT_WIDTH-1:0]              flush_count;
  // counter i lives in [i*CNT_WIDTH +: CNT_WIDTH]
  logic [NUM_EVT-1:0][CNT_WIDTH-1:0] evt_count;
  logic [RUN_WIDTH-1:0]              max_stall_run;
  logic [CNT_WIDTH-1:0]              snap_cycle;
  logic [CNT_WIDTH-1:0]              snap_instr;
  logic [CNT_WIDTH-1:0]              snap_stall;
  logic                              snap_valid;
  logic [NUM_EVT+3:0]                sat;
  logic                              timeout;
  logic [1:0]                        mon_state;

  modport master (
    output enable, clear, snapshot, retire, stall, flush, evt, wdt_limit,
    input  cycle_count, instr_count, stall_count, flush_count, evt_count,
           max_stall_run, snap_cycle, snap_instr, snap_stall, snap_valid,
           sat, timeout, mon_state
  );

  modport slave (
    input  enable, clear, snapshot, retire, stall, flush, evt, wdt_limit,
    output cycle_count, instr_count, stall_count, flush_count, evt_count,
           max_stall_run, snap_cycle, snap_instr, snap_stall, snap_valid,
           sat, timeout, mon_state
  );
endinterface

// File: rtl/vtx1_pipeline_monitor.sv
// VTX1 pipeline performance/health monitor: saturating event counters, longest stall run,
// retire watchdog with sticky timeout, and atomic snapshot / read-and-clear.

// One saturating event counter lane.
module vtx1_pmon_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  // Hold at all-ones; sat latches the first increment attempted there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (&cnt) sat <= 1'b1;
      else      cnt <= cnt + 1'b1;
    end
  end
endmodule

module vtx1_pipeline_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_EVT   = 4,
  parameter int RUN_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vtx1_pipeline_monitor_if.slave  mon
);
  // lane order matches the sat vector: cycle, instr, stall, flush, evt[0..]
  localparam int NCNT = NUM_EVT + 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic                           in_run;
  logic                           wdt_hit;
  logic [RUN_WIDTH-1:0]           run_q, max_q, wdt_q;
  logic [RUN_WIDTH-1:0]           run_inc, wdt_inc;
  logic [NCNT-1:0]                inc_vec;
  logic [NCNT-1:0]                sat_vec;
  logic [NCNT-1:0][CNT_WIDTH-1:0] cnt_vec;
  logic [CNT_WIDTH-1:0]           snap_cycle_q, snap_instr_q, snap_stall_q;
  logic                           snap_valid_q;
  logic                           timeout_q;

  assign in_run  = (state_q == ST_RUN);
  assign run_inc = (&run_q) ? run_q : run_q + 1'b1;
  assign wdt_inc = (&wdt_q) ? wdt_q : wdt_q + 1'b1;

  // Expiry is evaluated one bit wider so a limit of all-ones is still reachable
  assign wdt_hit = in_run && (mon.wdt_limit != '0) && !mon.retire &&
                   (({1'b0, wdt_q} + 1'b1) == {1'b0, mon.wdt_limit});

  // The expiry cycle itself is still a RUN cycle and is counted; HALT starts after it
  assign inc_vec = {mon.evt, mon.flush, mon.stall, mon.retire, 1'b1} & {NCNT{in_run}};

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    vtx1_pmon_cnt #(.W(CNT_WIDTH)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (mon.clear),
      .inc  (inc_vec[i]),
      .cnt  (cnt_vec[i]),
      .sat  (sat_vec[i])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: clear wins everywhere, HALT only leaves through clear
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mon.enable) state_d = ST_RUN;
      ST_RUN: begin
        if (wdt_hit)          state_d = ST_HALT;
        else if (!mon.enable) state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (mon.clear) state_d = ST_IDLE;
  end

  // Stall-run tracking, watchdog and sticky timeout; all frozen outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= '0;
      max_q     <= '0;
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (mon.clear) begin
      run_q     <= '0;
      max_q     <= '0;
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (in_run) begin
      if (mon.stall) begin
        run_q <= run_inc;
        if (run_inc > max_q) max_q <= run_inc;
      end else begin
        run_q <= '0;
      end
      if (mon.wdt_limit == '0 || mon.retire) wdt_q <= '0;
      else                                   wdt_q <= wdt_inc;
      if (wdt_hit) timeout_q <= 1'b1;
    end
  end

  // Snapshot takes the pre-update live values, so snapshot+clear is an atomic read-and-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_cycle_q <= '0;
      snap_instr_q <= '0;
      snap_stall_q <= '0;
      snap_valid_q <= 1'b0;
    end else if (mon.snapshot) begin
      snap_cycle_q <= cnt_vec[0];
      snap_instr_q <= cnt_vec[1];
      snap_stall_q <= cnt_vec[2];
      snap_valid_q <= 1'b1;
    end
  end

  assign mon.cycle_count   = cnt_vec[0];
  assign mon.instr_count   = cnt_vec[1];
  assign mon.stall_count   = cnt_vec[2];
  assign mon.flush_count   = cnt_vec[3];
  assign mon.evt_count     = cnt_vec[NCNT-1:4];
  assign mon.max_stall_run = max_q;
  assign mon.snap_cycle    = snap_cycle_q;
  assign mon.snap_instr    = snap_instr_q;
  assign mon.snap_stall    = snap_stall_q;
  assign mon.snap_valid    = snap_valid_q;
  assign mon.sat           = sat_vec;
  assign mon.timeout       = timeout_q;
  assign mon.mon_state     = state_q;
endmodule

// File: tb/tb_vtx1_pipeline_monitor.sv
// Bench for vtx1_pipeline_monitor: directed scenarios then randomized traffic, each cycle
// checked against a cycle-level behavioural model of the monitor's counting rules.
module tb_vtx1_pipeline_monitor;
  localparam int CW   = 6;
  localparam int NE   = 4;
  localparam int RW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int RMAX = (1 << RW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  vtx1_pipeline_monitor_if #(.CNT_WIDTH(CW), .NUM_EVT(NE), .RUN_WIDTH(RW)) mif ();

  vtx1_pipeline_monitor #(.CNT_WIDTH(CW), .NUM_EVT(NE), .RUN_WIDTH(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mon  (mif)
  );

  // model: index 0 cycle, 1 instr, 2 stall, 3 flush, 4.. evt
  int       m_cnt [NE+4];
  bit [NE+3:0] m_sat;
  int       m_run, m_max, m_wdt, m_state;
  int       m_sc, m_si, m_ss;
  bit       m_sv, m_to;

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_sat = '0; m_run = 0; m_max = 0; m_wdt = 0; m_state = 0;
    m_sc = 0; m_si = 0; m_ss = 0; m_sv = 0; m_to = 0;
  endtask

  // One clock edge of the monitor, computed from the inputs currently applied
  task automatic model_clk();
    bit strobe [NE+4];
    bit expire;
    if (mif.snapshot) begin
      m_sc = m_cnt[0]; m_si = m_cnt[1]; m_ss = m_cnt[2]; m_sv = 1;
    end
    if (mif.clear) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_sat = '0; m_run = 0; m_max = 0; m_wdt = 0; m_to = 0; m_state = 0;
      return;
    end
    if (m_state == 0) begin
      if (mif.enable) m_state = 1;
    end else if (m_state == 1) begin
      expire = (mif.wdt_limit != 0) && !mif.retire && (m_wdt + 1 == int'(mif.wdt_limit));
      strobe[0] = 1; strobe[1] = mif.retire; strobe[2] = mif.stall; strobe[3] = mif.flush;
      for (int i = 0; i < NE; i++) strobe[4+i] = mif.evt[i];
      for (int i = 0; i < NE + 4; i++)
        if (strobe[i]) begin
          if (m_cnt[i] == CMAX) m_sat[i] = 1;
          else m_cnt[i]++;
        end
      if (mif.stall) begin
        m_run = (m_run + 1 > RMAX) ? RMAX : m_run + 1;
        if (m_run > m_max) m_max = m_run;
      end else m_run = 0;
      if (mif.wdt_limit == 0 || mif.retire) m_wdt = 0;
      else m_wdt = (m_wdt + 1 > RMAX) ? RMAX : m_wdt + 1;
      if (expire) begin m_to = 1; m_state = 2; end
      else if (!mif.enable) m_state = 0;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    logic [NE-1:0][CW-1:0] e_evt;
    for (int i = 0; i < NE; i++) e_evt[i] = CW'(m_cnt[4+i]);
    chk({ph, ".cycle"}, 64'(mif.cycle_count), 64'(m_cnt[0]));
    chk({ph, ".instr"}, 64'(mif.instr_count), 64'(m_cnt[1]));
    chk({ph, ".stall"}, 64'(mif.stall_count), 64'(m_cnt[2]));
    chk({ph, ".flush"}, 64'(mif.flush_count), 64'(m_cnt[3]));
    chk({ph, ".evt"}, 64'(mif.evt_count), 64'(e_evt));
    chk({ph, ".maxrun"}, 64'(mif.max_stall_run), 64'(m_max));
    chk({ph, ".snap_cycle"}, 64'(mif.snap_cycle), 64'(m_sc));
    chk({ph, ".snap_instr"}, 64'(mif.snap_instr), 64'(m_si));
    chk({ph, ".snap_stall"}, 64'(mif.snap_stall), 64'(m_ss));
    chk({ph, ".snap_valid"}, 64'(mif.snap_valid), 64'(m_sv));
    chk({ph, ".sat"}, 64'(mif.sat), 64'(m_sat));
    chk({ph, ".timeout"}, 64'(mif.timeout), 64'(m_to));
    chk({ph, ".state"}, 64'(mif.mon_state), 64'(m_state));
  endtask

  task automatic step(string ph);
    model_clk();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    mif.enable = 0; mif.clear = 0; mif.snapshot = 0; mif.retire = 0;
    mif.stall = 0; mif.flush = 0; mif.evt = '0; mif.wdt_limit = '0;
  endtask

  task automatic do_clear(string ph);
    idle_inputs();
    mif.clear = 1;
    step(ph);
    mif.clear = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;

    // 1: one IDLE->RUN cycle then 10 RUN cycles retiring every cycle
    mif.enable = 1; mif.retire = 1;
    repeat (11) step("t1");
    chk("t1.cycle10", 64'(mif.cycle_count), 64'd10);
    chk("t1.instr10", 64'(mif.instr_count), 64'd10);
    chk("t1.state_run", 64'(mif.mon_state), 64'd1);

    // 2: stall 5 / 1 / 3
    mif.stall = 1; repeat (5) step("t2");
    mif.stall = 0; step("t2");
    mif.stall = 1; repeat (3) step("t2");
    mif.stall = 0;
    chk("t2.stall8", 64'(mif.stall_count), 64'd8);
    chk("t2.max5", 64'(mif.max_stall_run), 64'd5);

    // 3: watchdog, limit 8 without retire
    do_clear("t3");
    mif.enable = 1; mif.wdt_limit = RW'(8);
    repeat (9) step("t3");
    chk("t3.timeout", 64'(mif.timeout), 64'd1);
    chk("t3.halt", 64'(mif.mon_state), 64'd2);
    chk("t3.cycle8", 64'(mif.cycle_count), 64'd8);
    mif.retire = 1; repeat (3) step("t3h");
    chk("t3.frozen", 64'(mif.cycle_count), 64'd8);
    do_clear("t3c");
    chk("t3.to_clr", 64'(mif.timeout), 64'd0);
    chk("t3.idle", 64'(mif.mon_state), 64'd0);

    // 5: 12 RUN cycles then snapshot+clear with an evt pulse
    mif.enable = 1;
    repeat (13) step("t5");
    mif.snapshot = 1; mif.clear = 1; mif.evt = 4'b0001;
    step("t5sc");
    mif.snapshot = 0; mif.clear = 0; mif.evt = '0;
    chk("t5.snap12", 64'(mif.snap_cycle), 64'd12);
    chk("t5.cyc0", 64'(mif.cycle_count), 64'd0);
    chk("t5.evt0", 64'(mif.evt_count), 64'd0);

    // 4: evt[0] held long enough to saturate
    mif.enable = 1; mif.evt = 4'b0001;
    repeat (CMAX + 12) step("t4");
    chk("t4.evtmax", 64'(mif.evt_count[0]), 64'(CMAX));
    chk("t4.sat4", 64'(mif.sat[4]), 64'd1);
    mif.evt = '0;

    // long stall run saturates the run counter
    do_clear("t6");
    mif.enable = 1; mif.retire = 1; mif.stall = 1;
    repeat (RMAX + 10) step("t6");
    chk("t6.maxsat", 64'(mif.max_stall_run), 64'(RMAX));
    mif.stall = 0;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      mif.enable   = ($urandom_range(0, 7) != 0);
      mif.clear    = ($urandom_range(0, 79) == 0);
      mif.snapshot = ($urandom_range(0, 15) == 0);
      mif.retire   = ($urandom_range(0, 2) == 0);
      mif.stall    = ($urandom_range(0, 1) == 0);
      mif.flush    = ($urandom_range(0, 5) == 0);
      mif.evt      = NE'($urandom_range(0, (1 << NE) - 1));
      if ($urandom_range(0, 99) == 0)
        mif.wdt_limit = ($urandom_range(0, 2) == 0) ? '0 : RW'($urandom_range(3, 20));
      step("rnd");
    end

    // 6: async reset in the middle of a cycle
    idle_inputs();
    mif.enable = 1; mif.retire = 1; mif.snapshot = 1; mif.evt = '1;
    repeat (6) step("t6pre");
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    mif.enable = 1;
    repeat (4) step("post");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
